// File: rtl/reg_bank_2r1w.sv
// Register bank with two registered read ports, one write port, a per-register
// pending (reservation) bit and a sweep-clear engine that zeroes every entry.
// Ports: clk/reset (sync, active-high); we/waddr/wdata write port;
//   raddr_a/raddr_b -> rdata_a/rdata_b, pend_a/pend_b (1-cycle latency, bypassed);
//   rsv_en/rsv_addr set a pending bit; clr_req starts a sweep, busy high while it runs.
module reg_bank_2r1w #(
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = 4,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_a,
  output logic [WIDTH-1:0]  rdata_b,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              pend_a,
  output logic              pend_b,
  input  logic              clr_req,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;

  logic [WIDTH-1:0]  regs     [DEPTH];
  logic [WIDTH-1:0]  reg_nxt  [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [DEPTH-1:0]  pend_nxt;

  // Writes and reservations are dropped entirely while the sweep runs.
  logic wr_ok;
  logic rsv_ok;
  assign wr_ok  = we     && (state == IDLE);
  assign rsv_ok = rsv_en && (state == IDLE);

  // Post-edge value of every entry. Read ports sample this array directly,
  // which gives write-through bypass and shows the sweep's zero on the
  // address being cleared in the same cycle.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      reg_nxt[i]  = regs[i];
      pend_nxt[i] = pend[i];
      if (wr_ok && (waddr == ADDR_W'(i))) begin
        reg_nxt[i]  = wdata;
        pend_nxt[i] = 1'b0;
      end
      // Applied after the write so a same-cycle reservation leaves the bit set.
      if (rsv_ok && (rsv_addr == ADDR_W'(i))) begin
        pend_nxt[i] = 1'b1;
      end
      if ((state == CLEAR) && (idx == ADDR_W'(i))) begin
        reg_nxt[i]  = '0;
        pend_nxt[i] = 1'b0;
      end
      if (ZERO_REG && (i == 0)) begin
        reg_nxt[i]  = '0;
        pend_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      pend    <= '0;
      rdata_a <= '0;
      rdata_b <= '0;
      pend_a  <= 1'b0;
      pend_b  <= 1'b0;
      busy    <= 1'b0;
      idx     <= '0;
      state   <= IDLE;
    end else begin
      regs    <= reg_nxt;
      pend    <= pend_nxt;
      rdata_a <= reg_nxt[raddr_a];
      rdata_b <= reg_nxt[raddr_b];
      pend_a  <= pend_nxt[raddr_a];
      pend_b  <= pend_nxt[raddr_b];
      case (state)
        IDLE: begin
          if (clr_req) begin
            state <= CLEAR;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          // Last entry cleared on this edge: leave, index wraps back to 0.
          if (idx == '1) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          idx <= idx + 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bank_2r1w.sv
module tb_reg_bank_2r1w;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Instance A: defaults (16-bit, 16 entries, no zero register)
  logic        rst_a, we_a, rsv_en_a, clr_a, busy_a, pnd_a_a, pnd_b_a;
  logic [3:0]  wad_a, rad_a_a, rad_b_a, rsv_ad_a;
  logic [15:0] wdt_a, rdt_a_a, rdt_b_a;

  // Instance B: 32-bit, 8 entries, register 0 hard-wired to zero
  logic        rst_b, we_b, rsv_en_b, clr_b, busy_b, pnd_a_b, pnd_b_b;
  logic [2:0]  wad_b, rad_a_b, rad_b_b, rsv_ad_b;
  logic [31:0] wdt_b, rdt_a_b, rdt_b_b;

  reg_bank_2r1w dut_a (
    .clk(clk), .reset(rst_a), .we(we_a), .waddr(wad_a), .wdata(wdt_a),
    .raddr_a(rad_a_a), .raddr_b(rad_b_a), .rdata_a(rdt_a_a), .rdata_b(rdt_b_a),
    .rsv_en(rsv_en_a), .rsv_addr(rsv_ad_a), .pend_a(pnd_a_a), .pend_b(pnd_b_a),
    .clr_req(clr_a), .busy(busy_a)
  );

  reg_bank_2r1w #(.WIDTH(32), .ADDR_W(3), .ZERO_REG(1'b1)) dut_b (
    .clk(clk), .reset(rst_b), .we(we_b), .waddr(wad_b), .wdata(wdt_b),
    .raddr_a(rad_a_b), .raddr_b(rad_b_b), .rdata_a(rdt_a_b), .rdata_b(rdt_b_b),
    .rsv_en(rsv_en_b), .rsv_addr(rsv_ad_b), .pend_a(pnd_a_b), .pend_b(pnd_b_b),
    .clr_req(clr_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge and land 1 time unit after it for sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;

    rst_a = 1'b1; we_a = 0; rsv_en_a = 0; clr_a = 0;
    wad_a = 0; wdt_a = 0; rad_a_a = 0; rad_b_a = 0; rsv_ad_a = 0;
    rst_b = 1'b1; we_b = 0; rsv_en_b = 0; clr_b = 0;
    wad_b = 0; wdt_b = 0; rad_a_b = 0; rad_b_b = 0; rsv_ad_b = 0;

    // ---------------- reset state ----------------
    tick();
    tick();
    check("rst_rdata_a", 32'(rdt_a_a), 32'h0);
    check("rst_rdata_b", 32'(rdt_b_a), 32'h0);
    check("rst_pend_a",  32'(pnd_a_a), 32'h0);
    check("rst_pend_b",  32'(pnd_b_a), 32'h0);
    check("rst_busy",    32'(busy_a),  32'h0);
    rst_a = 1'b0;

    // ---------------- bypass ----------------
    we_a = 1; wad_a = 5; wdt_a = 16'hBEEF; rad_a_a = 5;
    tick();
    check("bypass_rdata", 32'(rdt_a_a), 32'hBEEF);
    check("bypass_pend",  32'(pnd_a_a), 32'h0);
    we_a = 0; wdt_a = 16'h0;
    tick();
    check("bypass_hold", 32'(rdt_a_a), 32'hBEEF);

    // ---------------- scoreboard ----------------
    rsv_en_a = 1; rsv_ad_a = 3; rad_b_a = 3; rad_a_a = 3;
    tick();
    rsv_en_a = 0;
    tick();
    check("sb_rsv_pend", 32'(pnd_b_a), 32'h1);
    we_a = 1; wad_a = 3; wdt_a = 16'h0012;
    tick();
    check("sb_wr_pend",  32'(pnd_b_a), 32'h0);
    check("sb_wr_data",  32'(rdt_b_a), 32'h0012);
    rsv_en_a = 1; rsv_ad_a = 3; wdt_a = 16'h0034;
    tick();
    check("sb_both_pend", 32'(pnd_b_a), 32'h1);
    check("sb_both_data", 32'(rdt_b_a), 32'h0034);
    check("sb_porta_same", 32'(rdt_a_a), 32'h0034);
    check("sb_porta_pend", 32'(pnd_a_a), 32'h1);
    we_a = 0; rsv_en_a = 0;

    // ---------------- sweep ----------------
    for (int i = 0; i < 16; i++) begin
      we_a = 1; wad_a = 4'(i); wdt_a = 16'(16'h1111 * i);
      tick();
    end
    we_a = 0;
    rad_a_a = 12;
    tick();
    check("fill_r12", 32'(rdt_a_a), 32'hCCCC);
    clr_a = 1;
    tick();
    clr_a = 0;
    check("sweep_busy_rise", 32'(busy_a), 32'h1);
    cnt = 0;
    while (busy_a && cnt < 40) begin
      cnt++;
      we_a    = (cnt == 11);         // r7 already cleared; write must be dropped
      wad_a   = 7;
      wdt_a   = 16'h7777;
      clr_a   = (cnt == 5);          // re-request during sweep must be ignored
      rad_b_a = 12;
      tick();
      if (cnt == 13) check("sweep_read_clearing", 32'(rdt_b_a), 32'h0);
    end
    we_a = 0; clr_a = 0;
    check("sweep_busy_cycles", 32'(cnt), 32'd16);
    for (int i = 0; i < 16; i++) begin
      rad_a_a = 4'(i); rad_b_a = 4'(i);
      tick();
      check($sformatf("sweep_r%0d", i), 32'(rdt_a_a), 32'h0);
    end
    check("sweep_pend3", 32'(pnd_b_a), 32'h0);

    // ---------------- clr_req + write + reservation together ----------------
    we_a = 1; wad_a = 4; wdt_a = 16'h4444; rsv_en_a = 1; rsv_ad_a = 4; clr_a = 1; rad_a_a = 4;
    tick();
    we_a = 0; rsv_en_a = 0; clr_a = 0;
    check("combo_data", 32'(rdt_a_a), 32'h4444);
    check("combo_pend", 32'(pnd_a_a), 32'h1);
    check("combo_busy", 32'(busy_a),  32'h1);
    cnt = 0;
    while (busy_a && cnt < 40) begin
      cnt++;
      tick();
    end
    check("combo_cycles", 32'(cnt), 32'd16);
    check("combo_cleared", 32'(rdt_a_a), 32'h0);
    check("combo_pend_clr", 32'(pnd_a_a), 32'h0);

    // ---------------- reset mid-sweep ----------------
    rsv_en_a = 1; rsv_ad_a = 14; we_a = 1; wad_a = 9; wdt_a = 16'h9999;
    tick();
    rsv_en_a = 0; we_a = 0;
    rad_a_a = 9; rad_b_a = 14;
    clr_a = 1;
    tick();
    clr_a = 0;
    for (int i = 0; i < 5; i++) tick();
    check("mid_busy_before", 32'(busy_a), 32'h1);
    rst_a = 1;
    tick();
    rst_a = 0;
    check("mid_rst_busy",   32'(busy_a),  32'h0);
    check("mid_rst_rdata_a", 32'(rdt_a_a), 32'h0);
    check("mid_rst_pend_b", 32'(pnd_b_a), 32'h0);
    we_a = 1; wad_a = 2; wdt_a = 16'hA5A5; rad_a_a = 2; rad_b_a = 9;
    tick();
    we_a = 0;
    check("post_rst_write", 32'(rdt_a_a), 32'hA5A5);
    check("post_rst_r9",    32'(rdt_b_a), 32'h0);
    check("post_rst_busy",  32'(busy_a),  32'h0);

    // ---------------- ZERO_REG instance ----------------
    check("zb_rst_rdata", rdt_a_b, 32'h0);
    check("zb_rst_busy", 32'(busy_b), 32'h0);
    rst_b = 0;
    we_b = 1; wad_b = 0; wdt_b = 32'hFFFFFFFF; rsv_en_b = 1; rsv_ad_b = 0; rad_a_b = 0;
    tick();
    we_b = 0; rsv_en_b = 0;
    check("zb_r0_data", rdt_a_b, 32'h0);
    check("zb_r0_pend", 32'(pnd_a_b), 32'h0);
    tick();
    check("zb_r0_data_hold", rdt_a_b, 32'h0);
    we_b = 1; wad_b = 1; wdt_b = 32'hDEADBEEF; rsv_en_b = 1; rsv_ad_b = 1; rad_b_b = 1;
    tick();
    we_b = 0; rsv_en_b = 0;
    check("zb_r1_data", rdt_b_b, 32'hDEADBEEF);
    check("zb_r1_pend", 32'(pnd_b_b), 32'h1);
    clr_b = 1;
    tick();
    clr_b = 0;
    cnt = 0;
    while (busy_b && cnt < 40) begin
      cnt++;
      tick();
    end
    check("zb_sweep_cycles", 32'(cnt), 32'd8);
    check("zb_r1_cleared", rdt_b_b, 32'h0);
    check("zb_r1_pend_clr", 32'(pnd_b_b), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
